csr_uart_tx: RTL
================

# csr_uart_tx

CSR-mapped serial transmit controller for the Polaris CPU's CSR bus. Software writes bytes to a DATA CSR; the block queues them in a FIFO and sequences each one out on `txd_o` as an 8N1 frame at a programmable bit rate. A CTRL CSR sets the divisor and reports status. It is the synthesizable, buffered counterpart of the simulation-only console CSR, with the same bus-side behaviour.

## Interface
- `ADDR_DATA`, 12'h0FC, CSR address of the DATA register
- `ADDR_CTRL`, 12'h0FD, CSR address of the CTRL register
- `FIFO_DEPTH`, 8, queue depth in bytes; power of two, 2..128
- `DIV_RESET`, 16'd867, bit-period divisor loaded at reset
- `clk_i`  in  1  clock; all state updates on posedge
- `reset_i`  in  1  synchronous, active-high reset
- `cadr_i`  in  12  CSR address
- `cvalid_o`  out  1  high when `cadr_i` equals `ADDR_DATA` or `ADDR_CTRL`
- `cdat_o`  out  64  read data; 0 when not selected
- `cdat_i`  in  64  write data
- `coe_i`  in  1  read strobe; no read side-effects exist, so it is ignored
- `cwe_i`  in  1  write strobe
- `txd_o`  out  1  serial output; idles high
- `busy_o`  out  1  high while a frame is on the line or the FIFO is non-empty

## Operation
- Decode: `cvalid_o` and `cdat_o` are purely combinational from `cadr_i` and current state. They must be valid in the first cycle of a CSR access.
- DATA read: [63:16]=0, [15:8]=FIFO count (zero-extended), [7:3]=0, [2]=overflow, [1]=empty, [0]=full.
- DATA write (`cwe_i` and DATA selected): pushes `cdat_i[7:0]`.
  - If the FIFO is full at the start of the cycle, the byte is dropped and sticky `overflow` is set. This holds even when a pop happens in the same cycle.
- CTRL read: [63:18]=0, [17]=`busy_o`, [16]=0, [15:0]=divisor.
- CTRL write: divisor <= `cdat_i[15:0]`.
  - If `cdat_i[16]`=1, clear `overflow`. If an overflow-setting event occurs in the same cycle, the clear loses.
- Serializer FSM, states IDLE/START/DATA/STOP:
  - IDLE: if the FIFO is non-empty, pop the head byte into the shift register, latch the divisor into `bitdiv`, load the bit timer with `bitdiv`, and go to START.
  - START: `txd_o`=0 for `bitdiv`+1 cycles, then go to DATA with bit index 0.
  - DATA: `txd_o` = shift[0], LSB first. Each bit lasts `bitdiv`+1 cycles. After bit 7, go to STOP.
  - STOP: `txd_o`=1 for `bitdiv`+1 cycles. At expiry, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Bit timer counts down from `bitdiv` to 0. A bit ends on the cycle the timer reads 0.
- A divisor write mid-frame affects only the next frame.
- Divisor 0 is legal: one cycle per bit.
- `busy_o` = (state != IDLE) | !empty.
- Simultaneous push and pop: both take effect, and the count is unchanged.

## Timing
- Reset values: `txd_o`=1, `busy_o`=0, `cdat_o`=0 when unselected, FIFO empty (count 0, empty=1, full=0), overflow=0, divisor=`DIV_RESET`, state IDLE.
- Reset asserted mid-frame: on the next edge `txd_o` returns to 1, the frame is aborted and queued bytes are discarded.
- Write to an empty FIFO while IDLE, at edge N:
  - After N: count=1, `busy_o`=1.
  - At edge N+1: pop; after N+1 `txd_o`=0 and count=0.
- Frame length is exactly 10×(`bitdiv`+1) cycles, with no gap between consecutive queued frames.
- Register writes are visible on reads from the cycle after the write edge.

## Test plan
- Reset, then read DATA and CTRL:
  - DATA reads 64'h2 (empty).
  - CTRL reads 867 in [15:0] with busy=0.
  - `txd_o`=1 and `cvalid_o`=0 for `cadr_i`=12'h0FF.
- Divisor=3, write 8'h55 to DATA:
  - `txd_o` is low 4 cycles starting one cycle after the write edge.
  - Then 1,0,1,0,1,0,1,0, 4 cycles each, then high 4 cycles.
  - `busy_o` falls 40 cycles after the frame starts.
- Divisor=0, write 8'hA1 and 8'h3C back-to-back: exactly 20 contiguous frame cycles with no idle cycle between the frames.
- Divisor=100 (0x64), nine writes while the first frame is in flight:
  - The first byte is popped, so the FIFO reaches 8/full.
  - The ninth write is dropped and DATA reads full=1, overflow=1.
  - A CTRL write of 32'h1_0064 clears overflow and keeps the divisor at 0x64.
- Change the divisor from 3 to 7 mid-frame: the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
- Assert `reset_i` for 1 cycle mid-DATA with 3 bytes queued: `txd_o`=1 next cycle, DATA reads 64'h2, and no further frames are sent.

Source files
------------

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 serial transmitter: DATA pushes bytes into a FIFO, CTRL holds the
// bit-period divisor and status; a four-state serializer drains the FIFO onto txd_o.
module csr_uart_tx #(
  parameter logic [11:0] ADDR_DATA  = 12'h0FC,
  parameter logic [11:0] ADDR_CTRL  = 12'h0FD,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [11:0] cadr_i,
  output logic        cvalid_o,
  output logic [63:0] cdat_o,
  input  logic [63:0] cdat_i,
  input  logic        coe_i,
  input  logic        cwe_i,
  output logic        txd_o,
  output logic        busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_divisor, r_bitdiv, r_timer;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitidx;

  logic          w_sel_data, w_sel_ctrl, w_empty, w_full;
  logic          w_push_req, w_push, w_pop, w_load, w_txd, w_ctrl_wr;
  logic [15:0]   w_bitdiv_nxt, w_timer_nxt;
  logic [7:0]    w_shift_nxt;
  logic [2:0]    w_bitidx_nxt;
  logic [63:0]   w_rdata;
  logic          w_unused;

  assign w_sel_data = (cadr_i == ADDR_DATA);
  assign w_sel_ctrl = (cadr_i == ADDR_CTRL);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_push_req = cwe_i & w_sel_data;
  assign w_push     = w_push_req & ~w_full;
  assign w_ctrl_wr  = cwe_i & w_sel_ctrl;
  assign w_unused   = ^{coe_i, cdat_i[63:17]};

  assign cvalid_o = w_sel_data | w_sel_ctrl;
  assign cdat_o   = w_rdata;
  assign txd_o    = w_txd;
  assign busy_o   = (r_state != S_IDLE) | ~w_empty;

  always_comb begin
    w_rdata = '0;
    if (w_sel_data)
      w_rdata = {48'd0, 8'(r_count), 5'd0, r_overflow, w_empty, w_full};
    else if (w_sel_ctrl)
      w_rdata = {46'd0, busy_o, 1'b0, r_divisor};
  end

  // Serializer: bit timer counts bitdiv..0, each bit ends when it reads 0
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_shift_nxt  = r_shift;
    w_bitdiv_nxt = r_bitdiv;
    w_bitidx_nxt = r_bitidx;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_txd        = 1'b1;
    case (r_state)
      S_IDLE: w_load = ~w_empty;
      S_START: begin
        w_txd = 1'b0;
        if (r_timer == 16'd0) begin
          w_state_nxt  = S_DATA;
          w_bitidx_nxt = 3'd0;
          w_timer_nxt  = r_bitdiv;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      S_DATA: begin
        w_txd = r_shift[0];
        if (r_timer == 16'd0) begin
          w_timer_nxt = r_bitdiv;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bitidx == 3'd7) w_state_nxt = S_STOP;
          else                  w_bitidx_nxt = r_bitidx + 3'd1;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      S_STOP: begin
        if (r_timer == 16'd0) begin
          if (w_empty) w_state_nxt = S_IDLE;
          else         w_load      = 1'b1;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The divisor is sampled only here, so mid-frame CTRL writes wait for the next frame
    if (w_load) begin
      w_pop        = 1'b1;
      w_shift_nxt  = r_mem[r_rptr];
      w_bitdiv_nxt = r_divisor;
      w_timer_nxt  = r_divisor;
      w_state_nxt  = S_START;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    r_timer  <= w_timer_nxt;
    r_shift  <= w_shift_nxt;
    r_bitdiv <= w_bitdiv_nxt;
    r_bitidx <= w_bitidx_nxt;
    if (w_push) r_mem[r_wptr] <= cdat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_divisor  <= DIV_RESET;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Full is judged at the start of the cycle, so a same-cycle pop does not save the byte
      if (w_push_req & w_full)          r_overflow <= 1'b1;
      else if (w_ctrl_wr & cdat_i[16])  r_overflow <= 1'b0;
      if (w_ctrl_wr) r_divisor <= cdat_i[15:0];
    end
  end
endmodule
